// File: rtl/gear_shift_controller.sv
// Transmission selector sequencer: P/R/N/D with brake/speed interlocks, timed neutral transit,
// low-gear hold with manual limit up/down. Async active-high reset; all outputs are registered.
module gear_shift_controller #(
  parameter int          SHIFT_TICKS    = 4,
  parameter int          PARK_SPEED_MAX = 0,
  parameter logic [3:0]  KEY_UP         = 4'd2,
  parameter logic [3:0]  KEY_DOWN       = 4'd8,
  parameter int          STEP_KMH       = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       engine_on,
  input  logic       tick_speed,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  input  logic [2:0] gear_num,
  input  logic       low_mode_sw,
  output logic [3:0] current_gear,
  output logic       is_low_gear_mode,
  output logic [2:0] max_gear_limit,
  output logic       shift_busy,
  output logic       shift_reject,
  output logic [2:0] reject_code
);

  localparam logic [3:0] G_P = 4'd3;
  localparam logic [3:0] G_R = 4'd6;
  localparam logic [3:0] G_N = 4'd9;
  localparam logic [3:0] G_D = 4'd12;

  localparam logic [2:0] RC_BRAKE  = 3'd1;
  localparam logic [2:0] RC_SPEED  = 3'd2;
  localparam logic [2:0] RC_BUSY   = 3'd3;
  localparam logic [2:0] RC_ENGINE = 3'd4;

  localparam logic [3:0] COUNT_LAST = 4'(SHIFT_TICKS - 1);
  localparam logic [7:0] PARK_MAX   = 8'(PARK_SPEED_MAX);

  typedef enum logic {
    ST_IDLE,
    ST_TRANSIT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gear_q, gear_d;
  logic [3:0] target_q, target_d;
  logic [3:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       reject_q, reject_d;
  logic [2:0] rcode_q, rcode_d;
  logic       low_q, low_d;
  logic [2:0] limit_q, limit_d;
  logic       engine_q;

  logic       brake;
  logic       is_sel;
  logic       engine_fall;
  logic       low_raw;
  logic [2:0] limit_dn;
  logic [8:0] down_thresh;
  logic [2:0] gear_clamped;
  logic       rej;
  logic [2:0] rej_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gear_q   <= G_P;
      target_q <= G_P;
      count_q  <= 4'd0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
      rcode_q  <= 3'd0;
      low_q    <= 1'b0;
      limit_q  <= 3'd6;
      engine_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gear_q   <= gear_d;
      target_q <= target_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      reject_q <= reject_d;
      rcode_q  <= rcode_d;
      low_q    <= low_d;
      limit_q  <= limit_d;
      engine_q <= engine_on;
    end
  end

  always_comb begin
    state_d      = state_q;
    gear_d       = gear_q;
    target_d     = target_q;
    count_d      = count_q;
    busy_d       = busy_q;
    reject_d     = 1'b0;
    rcode_d      = rcode_q;
    low_d        = low_q;
    limit_d      = limit_q;
    rej          = 1'b0;
    rej_code     = 3'd0;

    brake        = is_brake_normal | is_brake_hard;
    is_sel       = (key_code == G_P) || (key_code == G_R) ||
                   (key_code == G_N) || (key_code == G_D);
    engine_fall  = engine_q & ~engine_on;
    low_raw      = low_mode_sw & (gear_q == G_D) & ~busy_q;
    limit_dn     = (limit_q <= 3'd1) ? 3'd1 : limit_q - 3'd1;
    down_thresh  = 9'(STEP_KMH) * {6'd0, limit_dn};
    gear_clamped = (gear_num == 3'd0) ? 3'd1 :
                   (gear_num > 3'd6)  ? 3'd6 : gear_num;

    if (engine_fall) begin
      // Losing the engine drops straight to Park and abandons any transit.
      state_d = ST_IDLE;
      gear_d  = G_P;
      busy_d  = 1'b0;
      count_d = 4'd0;
      low_d   = 1'b0;
      limit_d = 3'd6;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            if (is_sel) begin
              if (key_code == gear_q) begin
                rej = 1'b0;
              end else if (!engine_on) begin
                rej = 1'b1; rej_code = RC_ENGINE;
              end else if (gear_q == G_P && !brake) begin
                rej = 1'b1; rej_code = RC_BRAKE;
              end else if ((key_code == G_P || key_code == G_R) && speed > PARK_MAX) begin
                rej = 1'b1; rej_code = RC_SPEED;
              end else if (key_code == G_D && gear_q == G_R && speed > PARK_MAX) begin
                rej = 1'b1; rej_code = RC_SPEED;
              end else begin
                target_d = key_code;
                gear_d   = G_N;
                busy_d   = 1'b1;
                count_d  = 4'd0;
                state_d  = ST_TRANSIT;
              end
            end else if (key_code == KEY_UP && low_q) begin
              limit_d = (limit_q >= 3'd6) ? 3'd6 : limit_q + 3'd1;
            end else if (key_code == KEY_DOWN && low_q) begin
              if ({1'b0, speed} < down_thresh) begin
                limit_d = limit_dn;
              end else begin
                rej = 1'b1; rej_code = RC_SPEED;
              end
            end
          end
        end
        ST_TRANSIT: begin
          if (tick_speed) begin
            if (count_q == COUNT_LAST) begin
              gear_d  = target_q;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              count_d = count_q + 4'd1;
            end
          end
          if (key_valid) begin
            rej = 1'b1; rej_code = RC_BUSY;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Mode entry latches the present gear as the ceiling; leaving it restores the full range.
      low_d = low_raw;
      if (low_raw && !low_q) begin
        limit_d = gear_clamped;
      end else if (!low_raw) begin
        limit_d = 3'd6;
      end
    end

    if (rej) begin
      reject_d = 1'b1;
      rcode_d  = rej_code;
    end
  end

  assign current_gear     = gear_q;
  assign is_low_gear_mode = low_q;
  assign max_gear_limit   = limit_q;
  assign shift_busy       = busy_q;
  assign shift_reject     = reject_q;
  assign reject_code      = rcode_q;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller: inputs change on negedge, outputs sampled on negedge.
module tb_gear_shift_controller;

  logic       clk;
  logic       rst;
  logic       engine_on;
  logic       tick_speed;
  logic       key_valid;
  logic [3:0] key_code;
  logic       is_brake_normal;
  logic       is_brake_hard;
  logic [7:0] speed;
  logic [2:0] gear_num;
  logic       low_mode_sw;
  logic [3:0] current_gear;
  logic       is_low_gear_mode;
  logic [2:0] max_gear_limit;
  logic       shift_busy;
  logic       shift_reject;
  logic [2:0] reject_code;

  int tests_run = 0;
  int failed    = 0;

  gear_shift_controller dut (
    .clk              (clk),
    .rst              (rst),
    .engine_on        (engine_on),
    .tick_speed       (tick_speed),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .is_brake_normal  (is_brake_normal),
    .is_brake_hard    (is_brake_hard),
    .speed            (speed),
    .gear_num         (gear_num),
    .low_mode_sw      (low_mode_sw),
    .current_gear     (current_gear),
    .is_low_gear_mode (is_low_gear_mode),
    .max_gear_limit   (max_gear_limit),
    .shift_busy       (shift_busy),
    .shift_reject     (shift_reject),
    .reject_code      (reject_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle key strobe; entered and left on a negedge.
  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_speed = 1'b1;
      @(negedge clk);
      tick_speed = 1'b0;
    end
  endtask

  task automatic test_reset;
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL reset_gear: got %0d expected 3", current_gear); end
    tests_run++; if (is_low_gear_mode !== 1'b0) begin failed++; $display("FAIL reset_low: got %0b expected 0", is_low_gear_mode); end
    tests_run++; if (max_gear_limit !== 3'd6) begin failed++; $display("FAIL reset_limit: got %0d expected 6", max_gear_limit); end
    tests_run++; if (shift_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b expected 0", shift_busy); end
    tests_run++; if (shift_reject !== 1'b0) begin failed++; $display("FAIL reset_reject: got %0b expected 0", shift_reject); end
    tests_run++; if (reject_code !== 3'd0) begin failed++; $display("FAIL reset_code: got %0d expected 0", reject_code); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL post_reset_gear: got %0d expected 3", current_gear); end
  endtask

  task automatic test_park_exit;
    engine_on = 1'b1;
    @(negedge clk);
    press(4'd12);
    tests_run++; if (shift_reject !== 1'b1) begin failed++; $display("FAIL park_nobrake_pulse: got %0b expected 1", shift_reject); end
    tests_run++; if (reject_code !== 3'd1) begin failed++; $display("FAIL park_nobrake_code: got %0d expected 1", reject_code); end
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL park_nobrake_gear: got %0d expected 3", current_gear); end
    @(negedge clk);
    tests_run++; if (shift_reject !== 1'b0) begin failed++; $display("FAIL reject_one_cycle: got %0b expected 0", shift_reject); end
    is_brake_normal = 1'b1;
    press(4'd12);
    tests_run++; if (current_gear !== 4'd9) begin failed++; $display("FAIL park_exit_neutral: got %0d expected 9", current_gear); end
    tests_run++; if (shift_busy !== 1'b1) begin failed++; $display("FAIL park_exit_busy: got %0b expected 1", shift_busy); end
    tick_n(3);
    tests_run++; if (current_gear !== 4'd9) begin failed++; $display("FAIL park_exit_3ticks: got %0d expected 9", current_gear); end
    tick_n(1);
    tests_run++; if (current_gear !== 4'd12) begin failed++; $display("FAIL park_exit_done_gear: got %0d expected 12", current_gear); end
    tests_run++; if (shift_busy !== 1'b0) begin failed++; $display("FAIL park_exit_done_busy: got %0b expected 0", shift_busy); end
    tests_run++; if (reject_code !== 3'd1) begin failed++; $display("FAIL reject_code_hold: got %0d expected 1", reject_code); end
    is_brake_normal = 1'b0;
  endtask

  task automatic test_speed_interlock;
    speed = 8'd40;
    press(4'd6);
    tests_run++; if (reject_code !== 3'd2) begin failed++; $display("FAIL r_speed_code: got %0d expected 2", reject_code); end
    tests_run++; if (current_gear !== 4'd12) begin failed++; $display("FAIL r_speed_gear: got %0d expected 12", current_gear); end
    @(negedge clk);
    speed = 8'd0;
    press(4'd6);
    tests_run++; if (current_gear !== 4'd9) begin failed++; $display("FAIL r_accept_gear: got %0d expected 9", current_gear); end
  endtask

  task automatic test_key_in_transit;
    tick_n(2);
    press(4'd9);
    tests_run++; if (shift_reject !== 1'b1) begin failed++; $display("FAIL transit_key_pulse: got %0b expected 1", shift_reject); end
    tests_run++; if (reject_code !== 3'd3) begin failed++; $display("FAIL transit_key_code: got %0d expected 3", reject_code); end
    tick_n(1);
    tests_run++; if (current_gear !== 4'd9) begin failed++; $display("FAIL transit_3ticks: got %0d expected 9", current_gear); end
    tick_n(1);
    tests_run++; if (current_gear !== 4'd6) begin failed++; $display("FAIL transit_done_gear: got %0d expected 6", current_gear); end
  endtask

  task automatic test_back_to_back;
    press(4'd12);
    tests_run++; if (current_gear !== 4'd9) begin failed++; $display("FAIL r_to_d_start: got %0d expected 9", current_gear); end
    tick_n(3);
    key_code   = 4'd3;
    key_valid  = 1'b1;
    tick_speed = 1'b1;
    @(negedge clk);
    key_valid  = 1'b0;
    tick_speed = 1'b0;
    tests_run++; if (current_gear !== 4'd12) begin failed++; $display("FAIL coincident_gear: got %0d expected 12", current_gear); end
    tests_run++; if (shift_busy !== 1'b0) begin failed++; $display("FAIL coincident_busy: got %0b expected 0", shift_busy); end
    tests_run++; if (reject_code !== 3'd3) begin failed++; $display("FAIL coincident_code: got %0d expected 3", reject_code); end
  endtask

  task automatic test_low_gear;
    gear_num    = 3'd4;
    low_mode_sw = 1'b1;
    @(negedge clk);
    tests_run++; if (is_low_gear_mode !== 1'b1) begin failed++; $display("FAIL low_enter: got %0b expected 1", is_low_gear_mode); end
    tests_run++; if (max_gear_limit !== 3'd4) begin failed++; $display("FAIL low_hold_limit: got %0d expected 4", max_gear_limit); end
    speed = 8'd100;
    press(4'd8);
    tests_run++; if (reject_code !== 3'd2) begin failed++; $display("FAIL down_fast_code: got %0d expected 2", reject_code); end
    tests_run++; if (max_gear_limit !== 3'd4) begin failed++; $display("FAIL down_fast_limit: got %0d expected 4", max_gear_limit); end
    speed = 8'd80;
    press(4'd8);
    tests_run++; if (max_gear_limit !== 3'd3) begin failed++; $display("FAIL down_ok_limit: got %0d expected 3", max_gear_limit); end
    tests_run++; if (shift_reject !== 1'b0) begin failed++; $display("FAIL down_ok_noreject: got %0b expected 0", shift_reject); end
    for (int i = 0; i < 3; i++) press(4'd2);
    tests_run++; if (max_gear_limit !== 3'd6) begin failed++; $display("FAIL up_saturate: got %0d expected 6", max_gear_limit); end
    press(4'd2);
    tests_run++; if (max_gear_limit !== 3'd6) begin failed++; $display("FAIL up_at_six: got %0d expected 6", max_gear_limit); end
    low_mode_sw = 1'b0;
    press(4'd8);
    tests_run++; if (is_low_gear_mode !== 1'b0) begin failed++; $display("FAIL low_exit: got %0b expected 0", is_low_gear_mode); end
    tests_run++; if (shift_reject !== 1'b0) begin failed++; $display("FAIL down_when_off: got %0b expected 0", shift_reject); end
    gear_num    = 3'd0;
    low_mode_sw = 1'b1;
    @(negedge clk);
    tests_run++; if (max_gear_limit !== 3'd1) begin failed++; $display("FAIL clamp_gear0: got %0d expected 1", max_gear_limit); end
    speed = 8'd20;
    press(4'd8);
    tests_run++; if (max_gear_limit !== 3'd1) begin failed++; $display("FAIL down_at_one: got %0d expected 1", max_gear_limit); end
    tests_run++; if (shift_reject !== 1'b0) begin failed++; $display("FAIL down_at_one_rej: got %0b expected 0", shift_reject); end
    low_mode_sw = 1'b0;
    speed       = 8'd0;
    @(negedge clk);
    tests_run++; if (max_gear_limit !== 3'd6) begin failed++; $display("FAIL low_exit_limit: got %0d expected 6", max_gear_limit); end
  endtask

  task automatic test_engine_off;
    press(4'd9);
    tests_run++; if (shift_busy !== 1'b1) begin failed++; $display("FAIL d_to_n_busy: got %0b expected 1", shift_busy); end
    tick_n(1);
    engine_on = 1'b0;
    @(negedge clk);
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL eoff_gear: got %0d expected 3", current_gear); end
    tests_run++; if (shift_busy !== 1'b0) begin failed++; $display("FAIL eoff_busy: got %0b expected 0", shift_busy); end
    tests_run++; if (is_low_gear_mode !== 1'b0) begin failed++; $display("FAIL eoff_low: got %0b expected 0", is_low_gear_mode); end
    tick_n(4);
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL eoff_stays_p: got %0d expected 3", current_gear); end
    is_brake_normal = 1'b1;
    press(4'd12);
    tests_run++; if (reject_code !== 3'd4) begin failed++; $display("FAIL eoff_key_code: got %0d expected 4", reject_code); end
    tests_run++; if (shift_reject !== 1'b1) begin failed++; $display("FAIL eoff_key_pulse: got %0b expected 1", shift_reject); end
  endtask

  task automatic test_async_reset;
    engine_on = 1'b1;
    @(negedge clk);
    press(4'd12);
    tests_run++; if (current_gear !== 4'd9) begin failed++; $display("FAIL ar_transit_gear: got %0d expected 9", current_gear); end
    tick_n(1);
    #2 rst = 1'b1;
    #1;
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL ar_gear: got %0d expected 3", current_gear); end
    tests_run++; if (shift_busy !== 1'b0) begin failed++; $display("FAIL ar_busy: got %0b expected 0", shift_busy); end
    tests_run++; if (reject_code !== 3'd0) begin failed++; $display("FAIL ar_code: got %0d expected 0", reject_code); end
    tests_run++; if (max_gear_limit !== 3'd6) begin failed++; $display("FAIL ar_limit: got %0d expected 6", max_gear_limit); end
    tests_run++; if (is_low_gear_mode !== 1'b0) begin failed++; $display("FAIL ar_low: got %0b expected 0", is_low_gear_mode); end
    tests_run++; if (shift_reject !== 1'b0) begin failed++; $display("FAIL ar_reject: got %0b expected 0", shift_reject); end
    #1 rst = 1'b0;
    tick_n(4);
    tests_run++; if (current_gear !== 4'd3) begin failed++; $display("FAIL ar_no_resume: got %0d expected 3", current_gear); end
  endtask

  initial begin
    rst             = 1'b1;
    engine_on       = 1'b0;
    tick_speed      = 1'b0;
    key_valid       = 1'b0;
    key_code        = 4'd0;
    is_brake_normal = 1'b0;
    is_brake_hard   = 1'b0;
    speed           = 8'd0;
    gear_num        = 3'd1;
    low_mode_sw     = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_park_exit;
    test_speed_interlock;
    test_key_in_transit;
    test_back_to_back;
    test_low_gear;
    test_engine_off;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/gear_shift_controller.md
Name: gear_shift_controller

Overview:
- Sequences the transmission inputs of the vehicle physics datapath. Produces current_gear (P/R/N/D codes), is_low_gear_mode and max_gear_limit from keypad shift requests and the low-gear DIP switch.
- Enforces brake and speed interlocks and inserts a timed neutral transit on every accepted selector change.
- Sits between the keypad decoder and the vehicle physics block. Consumes that block's speed and gear_num outputs.

Parameters:
- SHIFT_TICKS, 4, number of tick_speed pulses spent in neutral transit per accepted shift (1..15)
- PARK_SPEED_MAX, 0, maximum speed (km/h) at which P or R may be entered, or at which D may be entered from R
- KEY_UP, 4'd2, key_code for manual limit up
- KEY_DOWN, 4'd8, key_code for manual limit down
- STEP_KMH, 30, speed span per gear used by the downshift interlock

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- engine_on  in  1  engine running
- tick_speed  in  1  one-cycle timing strobe (physics rate)
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle
- key_code  in  4  3=P, 6=R, 9=N, 12=D, KEY_UP, KEY_DOWN; all other codes are ignored
- is_brake_normal  in  1  brake pedal, normal
- is_brake_hard  in  1  brake pedal, hard
- speed  in  8  current speed in km/h
- gear_num  in  3  current automatic gear (1..6)
- low_mode_sw  in  1  low-gear DIP switch level
- current_gear  out  4  selector code to the datapath
- is_low_gear_mode  out  1  low-gear limit active
- max_gear_limit  out  3  gear ceiling, 1..6
- shift_busy  out  1  high during neutral transit
- shift_reject  out  1  one-cycle pulse when a request is refused
- reject_code  out  3  reason for the last reject: 0 none, 1 brake required, 2 speed too high, 3 busy, 4 engine off

Behaviour:
- Reset values: current_gear=3 (P), is_low_gear_mode=0, max_gear_limit=6, shift_busy=0, shift_reject=0, reject_code=0. FSM state is IDLE and target is P.
- brake = is_brake_normal | is_brake_hard.
- IDLE state, on key_valid with a selector code X:
  - X equal to current_gear: ignore; no reject.
  - engine_on=0: reject, code 4.
  - Leaving P (current_gear=3) without brake: reject, code 1.
  - X=3 or X=6 with speed > PARK_SPEED_MAX: reject, code 2.
  - X=12 from current_gear=6 with speed > PARK_SPEED_MAX: reject, code 2.
  - Otherwise accept. On the next clk: target<=X, current_gear<=9, shift_busy<=1, count<=0, and the FSM moves to TRANSIT.
  - Rules are evaluated in the order listed; the first rule that matches decides.
- TRANSIT state:
  - count increments on each tick_speed.
  - When count reaches SHIFT_TICKS-1 and tick_speed=1: current_gear<=target, shift_busy<=0, FSM returns to IDLE.
  - Any key_valid in TRANSIT is refused: reject, code 3. The transit is not disturbed.
- Reject behaviour: shift_reject is high for exactly one cycle, in the cycle after key_valid. reject_code holds its value until the next reject or until reset.
- engine_on falling (any state): pending transit is cancelled in the next cycle. current_gear<=3, shift_busy<=0, FSM to IDLE, is_low_gear_mode<=0.
- Low-gear mode:
  - is_low_gear_mode = registered (low_mode_sw & current_gear==12 & !shift_busy).
  - On its 0->1 transition, max_gear_limit<=gear_num (gear_num 0 is clamped to 1). This holds the present gear.
  - When the mode is 0, max_gear_limit<=6.
- KEY_UP: valid only when is_low_gear_mode=1; otherwise the key is ignored with no reject. max_gear_limit increments and saturates at 6 with no reject.
- KEY_DOWN: valid only when is_low_gear_mode=1; otherwise the key is ignored with no reject.
  - New limit L' = max_gear_limit-1, which saturates at 1 with no reject.
  - Accepted only if speed < STEP_KMH*L'; otherwise reject, code 2.
  - The product is computed at 9 bits; STEP_KMH*6 must fit.
- Simultaneous events:
  - engine_on fall has priority over key handling.
  - Transit completion and key_valid in the same cycle: completion occurs and the key is rejected with code 3.
- Reset asserted mid-transit: all outputs return to their reset values immediately (asynchronous reset).

Test Plan:
- Shift out of Park:
  - Engine on, brake=0, key 12 from P -> shift_reject pulse, reject_code=1, current_gear stays 3.
  - Repeat with is_brake_normal=1 -> current_gear=9 and shift_busy=1 for 4 ticks, then current_gear=12 and shift_busy=0.
- Speed interlock on R: in D at speed=40, key 6 -> reject_code=2, gear stays 12. At speed=0 -> transit, then gear 6.
- Key during transit: key 9 during D->R transit -> reject_code=3, transit completes on schedule to 6.
- Low-gear hold and downshift:
  - In D with gear_num=4, set low_mode_sw=1 -> is_low_gear_mode=1, max_gear_limit=4.
  - KEY_DOWN at speed=100 -> reject code 2, limit stays 4.
  - KEY_DOWN at speed=80 -> limit 3.
  - KEY_UP three times -> limit saturates at 6.
- Engine off mid-transit: engine_on falls mid-transit -> next cycle current_gear=3, shift_busy=0, is_low_gear_mode=0. A following key 12 -> reject_code=4.
- Asynchronous reset: pulse rst between clock edges during transit -> all outputs equal their reset values before the next clk edge.
